// File: rtl/prog_loader.sv
// Boot-time instruction-memory loader: takes a length-prefixed, checksummed byte
// stream and writes big-endian 32-bit words from BASE_ADDR, holding the CPU until done.
module prog_loader #(
  parameter int unsigned                             NUM_BITS_ADDR_BARRAMENTO = 32,
  parameter int unsigned                             NUM_BITS_MEM_PROG        = 32,
  parameter logic [NUM_BITS_ADDR_BARRAMENTO-1:0]     BASE_ADDR                = '0,
  parameter int unsigned                             MAX_WORDS                = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [7:0]                          in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic                                mem_we,
  output logic [NUM_BITS_ADDR_BARRAMENTO-1:0] mem_addr,
  output logic [NUM_BITS_MEM_PROG-1:0]        mem_wd,
  output logic                                cpu_hold,
  output logic                                busy,
  output logic                                done,
  output logic                                error
);

  localparam int unsigned AW = NUM_BITS_ADDR_BARRAMENTO;
  localparam int unsigned DW = NUM_BITS_MEM_PROG;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CKSUM,
    S_DONE,
    S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic            hdr_idx_q, hdr_idx_d;
  logic [15:0]     count_q, count_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [15:0]     word_idx_q, word_idx_d;
  logic [DW-1:0]   word_q, word_d;
  logic [7:0]      sum_q, sum_d;
  logic            in_ready_q, in_ready_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wd_q, mem_wd_d;
  logic            cpu_hold_q, cpu_hold_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            xfer;
  logic [15:0]     hdr_full;
  logic [DW-1:0]   word_next;
  logic [7:0]      cksum_total;
  logic [15:0]     word_idx_inc;

  always_comb begin
    xfer         = in_valid && in_ready_q;
    hdr_full     = {count_q[15:8], in_data};
    word_next    = {word_q[DW-9:0], in_data};
    cksum_total  = sum_q + in_data;
    word_idx_inc = word_idx_q + 16'd1;

    state_d    = state_q;
    hdr_idx_d  = hdr_idx_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    word_d     = word_q;
    sum_d      = sum_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    cpu_hold_d = cpu_hold_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        // A reload from DONE re-asserts cpu_hold on the same edge that leaves DONE.
        if (start) begin
          state_d    = S_LEN;
          hdr_idx_d  = 1'b0;
          count_d    = '0;
          byte_idx_d = '0;
          word_idx_d = '0;
          word_d     = '0;
          sum_d      = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          busy_d     = 1'b1;
          cpu_hold_d = 1'b1;
        end
      end

      S_LEN: begin
        if (xfer) begin
          if (!hdr_idx_q) begin
            count_d[15:8] = in_data;
            hdr_idx_d     = 1'b1;
          end else begin
            count_d = hdr_full;
            if (hdr_full == 16'd0 || 32'(hdr_full) > MAX_WORDS) begin
              state_d = S_ERR;
              busy_d  = 1'b0;
              error_d = 1'b1;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (xfer) begin
          word_d     = word_next;
          sum_d      = cksum_total;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            state_d    = S_WRITE;
            mem_we_d   = 1'b1;
            mem_addr_d = BASE_ADDR + (AW'(word_idx_q) << 2);
            mem_wd_d   = word_next;
          end
        end
      end

      S_WRITE: begin
        word_idx_d = word_idx_inc;
        state_d    = (word_idx_inc == count_q) ? S_CKSUM : S_DATA;
      end

      S_CKSUM: begin
        if (xfer) begin
          busy_d = 1'b0;
          if (cksum_total == 8'h00) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CKSUM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      hdr_idx_q  <= 1'b0;
      count_q    <= '0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      word_q     <= '0;
      sum_q      <= '0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_idx_q  <= hdr_idx_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      word_q     <= word_d;
      sum_q      <= sum_d;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      cpu_hold_q <= cpu_hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign in_ready = in_ready_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wd   = mem_wd_q;
  assign cpu_hold = cpu_hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed and random load streams checked against a
// stream-level model of header, word writes and checksum outcome.
module tb_prog_loader;

  localparam int unsigned MAXW = 64;
  localparam logic [31:0] BASE = 32'h0000_0000;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  prog_loader #(
    .NUM_BITS_ADDR_BARRAMENTO(32),
    .NUM_BITS_MEM_PROG(32),
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wd(mem_wd),
    .cpu_hold(cpu_hold),
    .busy(busy),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] got_a[$];
  logic [31:0] got_d[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_d[$];
  int          exp_consumed;
  bit          exp_ok;

  always @(negedge clk) begin
    if (reset && mem_we) begin
      got_a.push_back(mem_addr);
      got_d.push_back(mem_wd);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected outcome of one stream, derived directly from the framing rules.
  function automatic void model(input bq_t b);
    int          cnt;
    logic [7:0]  sum;
    exp_a.delete();
    exp_d.delete();
    cnt = int'({b[0], b[1]});
    if (cnt == 0 || cnt > int'(MAXW)) begin
      exp_consumed = 2;
      exp_ok = 1'b0;
      return;
    end
    sum = 8'h00;
    for (int w = 0; w < cnt; w++) begin
      exp_a.push_back(BASE + 32'(4 * w));
      exp_d.push_back({b[2+4*w], b[3+4*w], b[4+4*w], b[5+4*w]});
      for (int k = 0; k < 4; k++) sum = sum + b[2+4*w+k];
    end
    exp_consumed = 2 + 4 * cnt + 1;
    exp_ok = (8'(sum + b[exp_consumed-1]) == 8'h00);
  endfunction

  function automatic bq_t make_stream(input int nwords, input bit good);
    bq_t        b;
    logic [7:0] sum;
    logic [7:0] v;
    b.push_back(8'(nwords >> 8));
    b.push_back(8'(nwords));
    sum = 8'h00;
    for (int i = 0; i < 4 * nwords; i++) begin
      v = 8'($urandom);
      b.push_back(v);
      sum = sum + v;
    end
    b.push_back(good ? 8'(-sum) : 8'(8'h01 - sum));
    return b;
  endfunction

  // mode 0: back-to-back, 1: valid on alternate cycles, 2: random gaps
  task automatic send_stream(input bq_t b, input int n, input int mode);
    int i;
    int cyc;
    bit pres;
    bit rdy;
    i = 0;
    cyc = 0;
    while (i < n && cyc < 4000) begin
      case (mode)
        0:       pres = 1'b1;
        1:       pres = (cyc % 2 == 0);
        default: pres = 1'($urandom_range(0, 1));
      endcase
      in_valid = pres;
      in_data  = pres ? b[i] : 8'($urandom);
      rdy = in_ready;
      @(posedge clk); #1;
      if (pres && rdy) i++;
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_accepted_all", 32'(i), 32'(n));
  endtask

  task automatic run_load(input string tag, input bq_t b, input int mode, input bit hold_start);
    int n;
    model(b);
    got_a.delete();
    got_d.delete();
    start = 1'b1;
    in_valid = 1'b1;
    in_data = b[0];
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    in_valid = 1'b0;
    check({tag, "_busy_on_start"}, 32'(busy), 32'd1);
    check({tag, "_hold_on_start"}, 32'(cpu_hold), 32'd1);
    check({tag, "_ready_on_start"}, 32'(in_ready), 32'd1);
    send_stream(b, exp_consumed, mode);
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'(exp_ok));
    check({tag, "_error"}, 32'(error), 32'(!exp_ok));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_ok));
    check({tag, "_ready_end"}, 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check({tag, "_nwrites"}, 32'(got_a.size()), 32'(exp_a.size()));
    n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, got_a[i], exp_a[i]);
      check({tag, "_data"}, got_d[i], exp_d[i]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wd"}, mem_wd, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    bq_t s2;
    bq_t s3;
    bq_t b;

    s2 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hC8};
    s3 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hC9};

    // 1: reset state, then idle with no stimulus
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("in_reset");
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check_reset_values("idle_after_reset");
    end

    // 2: normal load
    run_load("normal", s2, 0, 1'b0);

    // 3: checksum error
    run_load("bad_cksum", s3, 0, 1'b0);

    // 4: header bounds, last one exactly MAX_WORDS with start held high throughout
    b = '{8'h00, 8'h00};
    run_load("count_zero", b, 2, 1'b0);
    b = '{8'h00, 8'h41};
    run_load("count_over", b, 2, 1'b0);
    b = '{8'h01, 8'h00};
    run_load("count_hi", b, 2, 1'b0);
    b = make_stream(int'(MAXW), 1'b1);
    run_load("count_max", b, 2, 1'b1);

    // 5: flow control with gaps, including a byte offered during WRITE
    run_load("alt_valid", s2, 1, 1'b0);

    // random streams
    for (int r = 0; r < 5; r++) begin
      b = make_stream(int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
      run_load("random", b, 2, 1'b0);
    end

    // 6: reset one cycle after the first WRITE, then reload
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_stream(s2, 6, 0);
    check("mid_first_write_we", 32'(mem_we), 32'd1);
    check("mid_first_write_wd", mem_wd, 32'h1234_5678);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_reset_values("mid_load_reset");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_load("after_reset", s2, 0, 1'b0);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("reload_cpu_hold", 32'(cpu_hold), 32'd1);
    check("reload_busy", 32'(busy), 32'd1);
    check("reload_done", 32'(done), 32'd0);
    check("reload_in_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time writer for the instruction memory that the fetch path (program_counter + instruction_memory) reads.
- Receives a byte stream through a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word to consecutive word addresses from BASE_ADDR, checks an 8-bit checksum, and holds the CPU in reset until a load completes cleanly.

Parameters:
- NUM_BITS_ADDR_BARRAMENTO, 32, width of mem_addr.
- NUM_BITS_MEM_PROG, 32, instruction word width; fixed at 32 (4 bytes per word).
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- MAX_WORDS, 64, largest legal word count in the header.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse that begins a load; sampled only in IDLE, DONE, ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  instruction-memory write enable (1-cycle pulse per word).
- mem_addr  out  NUM_BITS_ADDR_BARRAMENTO  byte address of the word being written.
- mem_wd  out  NUM_BITS_MEM_PROG  word being written.
- cpu_hold  out  1  1 = keep the CPU (PC/reg_file) in reset.
- busy  out  1  load in progress.
- done  out  1  last load succeeded.
- error  out  1  last load failed.

Behaviour:
- Reset (reset=0, asynchronous), all values:
  - state=IDLE, cpu_hold=1, in_ready=0, mem_we=0.
  - mem_addr=0, mem_wd=0.
  - busy=0, done=0, error=0.
  - byte/word counters and checksum = 0.
- Byte transfer: occurs on a rising edge with in_valid=1 and in_ready=1. in_ready is decoded from state only, never from in_valid. No transfer when in_ready=0; the source holds the byte.
- Checksum: sum = 8-bit wrapping sum of payload bytes only (header and checksum bytes excluded).
- States:
  - IDLE: in_ready=0.
    - start → LEN. Clear counters, sum, done and error; set busy=1, cpu_hold=1.
  - LEN: in_ready=1.
    - Accept 2 bytes, MSB first, into a 16-bit count.
    - After the 2nd byte: count==0 or count>MAX_WORDS → ERR; else → DATA.
  - DATA: in_ready=1.
    - Each byte shifts into the word register MSB first and is added to sum.
    - 4th byte → WRITE.
  - WRITE: exactly 1 cycle.
    - in_ready=0, mem_we=1.
    - mem_addr = BASE_ADDR + 4*word_idx; mem_wd = assembled word.
    - word_idx increments. If word_idx+1==count → CKSUM; else → DATA.
    - mem_addr/mem_wd hold their last values after WRITE.
  - CKSUM: in_ready=1.
    - Accept 1 byte c. (sum + c) mod 256 == 0 → DONE; else → ERR.
  - DONE: busy=0, done=1, cpu_hold=0, in_ready=0.
    - start → LEN, with cpu_hold=1 on the same edge (reload).
  - ERR: busy=0, error=1, cpu_hold=1, in_ready=0.
    - start → LEN, error cleared.
- Latency:
  - mem_we is asserted the cycle after the 4th byte of a word is accepted.
  - done/error are asserted the cycle after the deciding byte is accepted.
- Boundary conditions:
  - start while busy is ignored.
  - start and a byte in the same IDLE cycle: the byte is not consumed.
  - Count == MAX_WORDS is legal; the last address is BASE_ADDR+4*(MAX_WORDS-1). mem_addr wraps modulo 2^NUM_BITS_ADDR_BARRAMENTO.
  - Reset mid-load returns all outputs to reset values immediately. Words already written are not undone.
  - No timeout: the loader waits indefinitely for in_valid.

Test Plan:
1. Reset released with no stimulus → cpu_hold=1, in_ready=0, mem_we=0, busy=done=error=0, held for 10 cycles.
2. Normal load, bytes 00 02, 12 34 56 78, 9A BC DE F0, C8 sent back-to-back:
   - mem_we pulse at addr 0x0 with data 0x12345678.
   - mem_we pulse at addr 0x4 with data 0x9ABCDEF0.
   - Then done=1, cpu_hold=0, busy=0.
3. Checksum error: same stream with checksum byte C9 → both writes occur, then error=1, done=0, cpu_hold=1.
4. Bad header: count 00 00 → error=1, no mem_we. With MAX_WORDS=64, count 00 41 → error=1, no mem_we. count 00 40 → load accepted.
5. Flow control: test-2 stream with in_valid low on alternate cycles and a byte presented during WRITE → no byte lost or duplicated, identical writes and done=1.
6. Reset mid-load and reload:
   - reset=0 one cycle after the first WRITE → all outputs return to reset values.
   - Rerun test 2 → correct completion.
   - Then start from DONE → cpu_hold=1 on the next edge, busy=1.
